// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad column scanner.
// Optional build macro KEYPAD_GHOST_REJECT_EN is consumed by keypad_scanner.
package keypad_pkg;

    typedef enum logic {SCAN, HELD} scan_state_t;

    localparam int         NCOL     = 4;
    localparam logic [3:0] COL_IDLE = 4'b1110;

    // Nibble {row,col} holds the legend printed on that key; entry 0 is the low nibble.
    localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;

    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd3;
        if (!r[0])      idx = 2'd0;
        else if (!r[1]) idx = 2'd1;
        else if (!r[2]) idx = 2'd2;
        return idx;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_TABLE[{row, col, 2'b00} +: 4];
    endfunction

    function automatic logic multi_low(input logic [3:0] r);
        logic [3:0] n;
        n = ~r;
        return |(n & (n - 4'd1));
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and debouncer-side signals of the scanner, grouped for binding.
// key is valid only while pressed is high; there is no backpressure (valid-only, no ready).
interface keypad_if;
    import keypad_pkg::*;

    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        pressed;
    logic [3:0]  key;
    scan_state_t state;

    modport master (input rows, output cols, output pressed, output key, output state);
    modport slave  (output rows, input cols, input pressed, input key, input state);

endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up lines read as released.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column scanner: walks an active-low column, locks the first key seen and holds it until release.
// Define KEYPAD_GHOST_REJECT_EN to ignore scans where more than one row reads low.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 12000
) (
    input  logic   int_osc,
    input  logic   reset,
    keypad_if.master kp
);

    localparam int CW = $clog2(SCAN_DIV);

`ifdef KEYPAD_GHOST_REJECT_EN
    localparam bit GHOST_REJECT = 1'b1;
`else
    localparam bit GHOST_REJECT = 1'b0;
`endif

    logic [3:0]    rows_s;
    logic [CW-1:0] cnt;
    logic          tick;

    scan_state_t   state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    key_q, key_d;
    logic          pressed_q, pressed_d;

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk   (int_osc),
        .rst_n (reset),
        .d     (kp.rows),
        .q     (rows_s)
    );

    // Decisions happen only on the last dwell cycle, so the rows have settled after a column change.
    assign tick = (cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            key_q     <= 4'h0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            key_q     <= key_d;
            pressed_q <= pressed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        key_d     = key_q;
        pressed_d = pressed_q;
        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (rows_s == 4'hF || (GHOST_REJECT && multi_low(rows_s))) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d     = lowest_low(rows_s);
                        key_d     = key_code(lowest_low(rows_s), col_q);
                        pressed_d = 1'b1;
                        state_d   = HELD;
                    end
                end
            end
            HELD: begin
                // Only the locked row can end the hold; other rows are ignored.
                if (tick && rows_s[row_q]) begin
                    state_d   = SCAN;
                    pressed_d = 1'b0;
                    col_d     = col_q + 2'd1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign kp.cols    = ~(4'b0001 << col_q);
    assign kp.pressed = pressed_q;
    assign kp.key     = key_q;
    assign kp.state   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4 and a switch-matrix keypad model.
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic        int_osc;
    logic        reset;
    logic [15:0] key_down;
    logic [3:0]  rows_m;
    int          checks;
    int          failures;

    keypad_if kp();

    keypad_scanner #(.SCAN_DIV(4)) dut (
        .int_osc (int_osc),
        .reset   (reset),
        .kp      (kp)
    );

    // Clock / reset
    initial int_osc = 1'b0;
    always #5 int_osc = ~int_osc;

    // Keypad matrix: a row reads low when a pressed key sits on the driven-low column.
    always_comb begin
        rows_m = 4'hF;
        for (int r = 0; r < 4; r++) begin
            rows_m[r] = ~|(key_down[r*4 +: 4] & ~kp.cols);
        end
    end
    assign kp.rows = rows_m;

    task automatic wait_edges(input int n);
        repeat (n) @(negedge int_osc);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input int r, input int c);
        key_down[r*4 + c] = 1'b1;
    endtask

    task automatic release_key(input int r, input int c);
        key_down[r*4 + c] = 1'b0;
    endtask

    logic [3:0] col_seq [4];

    initial begin
        checks   = 0;
        failures = 0;
        key_down = '0;
        col_seq[0] = 4'b1110;
        col_seq[1] = 4'b1101;
        col_seq[2] = 4'b1011;
        col_seq[3] = 4'b0111;
        reset = 1'b0;
        wait_edges(2);

        chk("rst_cols",    kp.cols,               4'b1110);
        chk("rst_pressed", {3'b0, kp.pressed},    4'h0);
        chk("rst_key",     kp.key,                4'h0);
        chk("rst_state",   {3'b0, kp.state},      {3'b0, SCAN});
        reset = 1'b1;

        // Idle scan: one column per 4 cycles
        for (int k = 0; k < 10; k++) begin
            chk("scan_cols", kp.cols, col_seq[k % 4]);
            chk("scan_pressed", {3'b0, kp.pressed}, 4'h0);
            wait_edges(4);
        end
        chk("scan_col2_again", kp.cols, 4'b1011);

        // Key '6' (row 1, column 2)
        press(1, 2);
        wait_edges(3);
        chk("k6_before_tick", {3'b0, kp.pressed}, 4'h0);
        wait_edges(1);
        chk("k6_pressed", {3'b0, kp.pressed}, 4'h1);
        chk("k6_key",     kp.key,             4'h6);
        chk("k6_state",   {3'b0, kp.state},   {3'b0, HELD});
        wait_edges(8);
        chk("k6_cols_frozen", kp.cols,             4'b1011);
        chk("k6_still_held",  {3'b0, kp.pressed},  4'h1);

        release_key(1, 2);
        wait_edges(3);
        chk("k6_rel_before_tick", {3'b0, kp.pressed}, 4'h1);
        wait_edges(1);
        chk("k6_rel_pressed", {3'b0, kp.pressed}, 4'h0);
        chk("k6_rel_key",     kp.key,             4'h6);
        chk("k6_rel_cols",    kp.cols,            4'b0111);

        // Rows 0 and 2 together on column 0
        press(0, 0);
        press(2, 0);
        wait_edges(8);
`ifdef KEYPAD_GHOST_REJECT_EN
        chk("ghost_pressed", {3'b0, kp.pressed}, 4'h0);
        chk("ghost_cols",    kp.cols,            4'b1101);
        chk("ghost_key",     kp.key,             4'h6);
`else
        chk("multi_pressed", {3'b0, kp.pressed}, 4'h1);
        chk("multi_key",     kp.key,             4'h1);
        chk("multi_cols",    kp.cols,            4'b1110);
`endif
        release_key(0, 0);
        release_key(2, 0);
        wait_edges(4);
`ifdef KEYPAD_GHOST_REJECT_EN
        chk("ghost_rel_pressed", {3'b0, kp.pressed}, 4'h0);
        chk("ghost_rel_cols",    kp.cols,            4'b1011);
`else
        chk("multi_rel_pressed", {3'b0, kp.pressed}, 4'h0);
        chk("multi_rel_key",     kp.key,             4'h1);
        chk("multi_rel_cols",    kp.cols,            4'b1101);
`endif

        // Re-align scan phase, then hold 'D' (row 3, column 3)
        reset = 1'b0;
        wait_edges(1);
        reset = 1'b1;
        press(3, 3);
        wait_edges(15);
        chk("kD_before_tick", {3'b0, kp.pressed}, 4'h0);
        wait_edges(1);
        chk("kD_pressed", {3'b0, kp.pressed}, 4'h1);
        chk("kD_key",     kp.key,             4'hD);
        chk("kD_cols",    kp.cols,            4'b0111);

        press(0, 3);
        wait_edges(8);
        chk("kD_other_row_key",     kp.key,            4'hD);
        chk("kD_other_row_pressed", {3'b0, kp.pressed}, 4'h1);

        release_key(3, 3);
        wait_edges(4);
        chk("kD_rel_pressed", {3'b0, kp.pressed}, 4'h0);
        chk("kD_rel_key",     kp.key,             4'hD);
        chk("kD_rel_cols",    kp.cols,            4'b1110);

        wait_edges(16);
        chk("kA_pressed", {3'b0, kp.pressed}, 4'h1);
        chk("kA_key",     kp.key,             4'hA);

        // Asynchronous reset in the middle of a hold
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_pressed", {3'b0, kp.pressed}, 4'h0);
        chk("async_rst_cols",    kp.cols,            4'b1110);
        chk("async_rst_key",     kp.key,             4'h0);
        chk("async_rst_state",   {3'b0, kp.state},   {3'b0, SCAN});
        wait_edges(1);
        reset = 1'b1;
        wait_edges(3);
        chk("restart_col0", kp.cols, 4'b1110);
        wait_edges(1);
        chk("restart_col1", kp.cols, 4'b1101);
        wait_edges(11);
        chk("relock_before_tick", {3'b0, kp.pressed}, 4'h0);
        wait_edges(1);
        chk("relock_pressed", {3'b0, kp.pressed}, 4'h1);
        chk("relock_key",     kp.key,             4'hA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the keypad debouncer in the 4x4 keypad / dual seven-segment display design.
- Drives the keypad columns active-low one at a time and samples the rows (pulled up, active-low) through a 2-flop synchronizer.
- Locks onto the first detected key and presents `pressed` plus a 4-bit hex key code (`key`) to the debouncer's `pressed`/`itemp` inputs until that key is released.

Parameters:
- SCAN_DIV, 12000, clock cycles per column dwell (1 ms at 12 MHz); minimum 4.
- NCOL, 4, number of columns (fixed at 4; present for package constants only).

Ports:
- int_osc  input  1  system clock (HFOSC-derived, 12 MHz).
- reset  input  1  asynchronous, active-low reset.
- rows  input  4  raw keypad row lines, active-low, asynchronous to int_osc.
- cols  output  4  column drive, active-low, exactly one bit low at all times.
- pressed  output  1  high while a key is locked.
- key  output  4  hex code of the locked key; valid while pressed=1.

Behaviour:
- Reset (reset=0, async): cols=4'b1110, pressed=0, key=4'h0, state=SCAN, dwell counter=0, column index=0, synchronizer flops=4'b1111.
- Synchronizer: rows_s = rows delayed 2 int_osc cycles; all decisions use rows_s only.
- Dwell counter: counts 0..SCAN_DIV-1, wraps to 0. A "tick" is a cycle with count==SCAN_DIV-1. The counter runs in every state.
- States: SCAN and HELD.
- SCAN, tick, rows_s==4'b1111:
  - column index increments mod 4 (3 wraps to 0).
  - cols = ~(1<<index) takes effect on the same edge.
- SCAN, tick, any rows_s bit low:
  - lock row r = lowest-index low bit and the current column c.
  - key <= code(r,c); state <= HELD; pressed=1 from the next cycle.
  - column does not advance.
- Key codes, row r / col 0..3:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- HELD:
  - cols stays on the locked column; key is held constant.
  - rows_s is evaluated only on ticks.
  - On a tick with locked row bit rows_s[r]==1: state <= SCAN, pressed <= 0, key holds its last value, column index advances by 1.
  - Other rows going low while HELD are ignored, with no key change.
- Sampling only on ticks gives ≥SCAN_DIV-2 cycles of column settle after a column change.
- Mid-operation reset: all of the above reset values apply immediately, with no completion of the scan or lock.
- pressed and key are registered outputs.
- Worst-case detection latency: 4*SCAN_DIV+2 cycles from the row edge.

Optional Feature:
- KEYPAD_GHOST_REJECT_EN
- Defined: in SCAN, a tick where rows_s has more than one low bit is treated as no key; the column advances and nothing locks. Rejects ghosting from multi-key presses.
- Undefined: lowest-index low row wins, as in Behaviour.

Decomposition:
- Package keypad_pkg contains:
  - typedef enum logic {SCAN, HELD} scan_state_t.
  - 16-entry constant key-code table, indexed {row,col}.
  - COL_IDLE constant 4'b1110.
  - Helper function lowest_low(logic[3:0]) returning a 2-bit row index.
- Sub-module sync2: parameterized-width 2-flop synchronizer with async active-low reset to all-ones. Instantiated once for rows.

Test Plan:
All tests use SCAN_DIV=4.
- Reset, rows=4'hF for 40 cycles -> cols cycles 1110,1101,1011,0111,1110 every 4 cycles; pressed=0, key=0.
- Hold rows[1] low only while cols=1011 -> within 1 tick of that column: pressed=1, key=4'h6; cols frozen at 1011 while held.
- Release rows[1] -> pressed=0 on the next tick edge, key stays 4'h6, cols advances to 0111.
- rows[0] and rows[2] low together on column 0:
  - macro off -> key=4'h1.
  - macro on -> pressed stays 0 and scanning continues.
- While HELD on key 'D' (r3,c3), pull rows[0] low, then release rows[3] -> key stays D until release; after the unlock, key '3'/'A' locks on a later scan.
- Assert reset=0 mid-HELD, asynchronously between edges -> pressed=0, cols=1110, key=0 immediately; after release, scanning restarts from column 0.
